// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the trigger link: FSM state encoding and default pulse timing
// constants used by both the transmit (stretcher) and receive sides.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int DEF_MIN_HIGH = 4;
  localparam int DEF_MIN_LOW  = 4;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger-link transmit bundle: request/config inputs towards the stretcher and its status outputs.
interface pulse_stretcher_if #(
  parameter int CNT_W  = 16,
  parameter int MISS_W = 8
);

  logic              trigger;
  logic [CNT_W-1:0]  delay;
  logic [CNT_W-1:0]  width;
  logic              retrig_en;
  logic              abort;
  logic              pulse_out;
  logic              busy;
  logic              done;
  logic [MISS_W-1:0] miss_cnt;

  modport master (
    output trigger, delay, width, retrig_en, abort,
    input  pulse_out, busy, done, miss_cnt
  );

  modport slave (
    input  trigger, delay, width, retrig_en, abort,
    output pulse_out, busy, done, miss_cnt
  );

endinterface

// File: rtl/pulse_stretcher.sv
// Turns a single-cycle trigger into a delayed pulse of at least MIN_HIGH cycles followed by
// at least MIN_LOW low cycles, so a slow synchronizer+edge detector on the far side never misses it.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MIN_HIGH = DEF_MIN_HIGH,
  parameter int MIN_LOW  = DEF_MIN_LOW,
  parameter int MISS_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pulse_stretcher_if.slave bus
);

  localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] GAP_LOAD_C = CNT_W'(MIN_LOW - 1);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  effW_q, effW_d;
  logic [CNT_W-1:0]  effWIn;
  logic              pulse_q, pulse_d;
  logic              done_q, done_d;
  logic              drop;
  logic [MISS_W-1:0] missCnt_q, missCnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      effW_q  <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      effW_q  <= effW_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  // The counter is loaded with (length - 1) on entry to each timed state and the state is left
  // on the cycle it reads zero, so every phase lasts exactly its programmed number of cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    effW_d  = effW_q;
    pulse_d = pulse_q;
    done_d  = 1'b0;
    drop    = 1'b0;
    effWIn  = (bus.width < MIN_HIGH_C) ? MIN_HIGH_C : bus.width;

    case (state_q)
      IDLE: begin
        if (bus.trigger && !bus.abort) begin
          effW_d = effWIn;
          if (bus.delay == '0) begin
            state_d = HIGH;
            cnt_d   = effWIn - ONE_C;
            pulse_d = 1'b1;
          end else begin
            state_d = DELAY;
            cnt_d   = bus.delay - ONE_C;
          end
        end
      end

      DELAY: begin
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          drop = bus.trigger;
          if (cnt_q == '0) begin
            state_d = HIGH;
            cnt_d   = effW_q - ONE_C;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end
      end

      // A retrigger reloads the latched width rather than the live inputs, keeping the line high.
      HIGH: begin
        if (bus.abort) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD_C;
          pulse_d = 1'b0;
          done_d  = 1'b1;
        end else if (bus.trigger && bus.retrig_en) begin
          cnt_d = effW_q - ONE_C;
        end else begin
          drop = bus.trigger;
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD_C;
            pulse_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end
      end

      GAP: begin
        drop = bus.trigger && !bus.abort;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
    endcase
  end

  always_comb begin
    missCnt_d = missCnt_q;
    if (drop && (missCnt_q != '1)) begin
      missCnt_d = missCnt_q + MISS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      missCnt_q <= '0;
    end else begin
      missCnt_q <= missCnt_d;
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.miss_cnt  = missCnt_q;

endmodule
